// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-RAM arbiter: FSM states, port identifiers
// and the wait-state ceiling.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_DONE
   } arb_state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } arb_port_t;

   localparam int unsigned MAX_WAIT = 15;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the port
// that was not granted last time wins.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,          // [0] = port I, [1] = port D
   input  arb_port_t  last_grant_i,
   output logic       grant_valid_o,
   output arb_port_t  grant_port_o
);

   always_comb begin
      grant_valid_o = |req_i;
      grant_port_o  = PORT_I;
      if (req_i == 2'b11) begin
         grant_port_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
      end else if (req_i[1]) begin
         grant_port_o = PORT_D;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port RAM (combinational read, posedge write) between an instruction
// port and a load/store port, with round-robin grant and programmable wait states.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic [31:0] i_readdata,
   output logic        i_waitrequest,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   output logic [31:0] d_readdata,
   output logic        d_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   output arb_state_t  dbg_state_o
);

   // Handshake: a master raises its strobe with address/data and holds them until it
   // sees its waitrequest low; that single low cycle is the completion cycle.

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   arb_port_t        grant_q, grant_d;
   arb_port_t        last_grant_q, last_grant_d;
   logic [31:0]      i_rdata_q, i_rdata_d;
   logic [31:0]      d_rdata_q, d_rdata_d;

   logic             d_req;
   logic             granted_req;
   logic [31:0]      granted_addr;
   logic             pick_valid;
   arb_port_t        pick_port;

   assign d_req        = d_read | d_write;
   assign granted_req  = (grant_q == PORT_I) ? i_read : d_req;
   assign granted_addr = (grant_q == PORT_I) ? i_address : d_address;
   assign dbg_state_o  = state_q;

   rr_pick2 u_pick (
      .req_i         ({d_req, i_read}),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (pick_valid),
      .grant_port_o  (pick_port)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         cnt_q        <= '0;
         grant_q      <= PORT_I;
         last_grant_q <= PORT_D;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      i_rdata_d     = i_rdata_q;
      d_rdata_d     = d_rdata_q;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = i_rdata_q;
      d_readdata    = d_rdata_q;
      mem_address   = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_writedata = '0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_port;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            mem_address = granted_addr;
            // A withdrawn request abandons the transfer without touching last_grant.
            if (!granted_req) begin
               state_d = ARB_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            mem_address = granted_addr;
            state_d     = ARB_IDLE;
            if (granted_req) begin
               last_grant_d = grant_q;
               if (grant_q == PORT_I) begin
                  mem_read      = 1'b1;
                  i_waitrequest = 1'b0;
                  i_readdata    = mem_readdata;
                  i_rdata_d     = mem_readdata;
               end else begin
                  // Write wins when both D strobes are up.
                  mem_write     = d_write;
                  mem_read      = d_read & ~d_write;
                  mem_writedata = d_writedata;
                  d_waitrequest = 1'b0;
                  if (!d_write) begin
                     d_readdata = mem_readdata;
                     d_rdata_d  = mem_readdata;
                  end
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always @(posedge clk) begin
      if (rst_n) begin
         rw_exclusive: assert (!(d_read && d_write))
            else $warning("dmem_arbiter: d_read and d_write both high, treated as write");
         req_held: assert (!(state_q != ARB_IDLE && !granted_req))
            else $warning("dmem_arbiter: granted master withdrew its request, transfer dropped");
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (0 and 3 wait states), each paired with a
// combinational-read / posedge-write RAM, checked against a transaction-level model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_address[2];
   logic        i_read[2];
   logic [31:0] i_readdata[2];
   logic        i_waitrequest[2];
   logic [31:0] d_address[2];
   logic        d_read[2];
   logic        d_write[2];
   logic [31:0] d_writedata[2];
   logic [31:0] d_readdata[2];
   logic        d_waitrequest[2];
   logic [31:0] mem_address[2];
   logic        mem_read[2];
   logic        mem_write[2];
   logic [31:0] mem_writedata[2];
   logic [31:0] mem_readdata[2];
   arb_state_t  dbg_state[2];

   logic [31:0] ram[2][1024];
   bit          wr_flag[2][1024];
   logic [31:0] model_mem[2][1024];
   arb_port_t   last_served[2];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_err = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   dmem_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_address(i_address[0]), .i_read(i_read[0]), .i_readdata(i_readdata[0]),
      .i_waitrequest(i_waitrequest[0]),
      .d_address(d_address[0]), .d_read(d_read[0]), .d_write(d_write[0]),
      .d_writedata(d_writedata[0]), .d_readdata(d_readdata[0]), .d_waitrequest(d_waitrequest[0]),
      .mem_address(mem_address[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
      .mem_writedata(mem_writedata[0]), .mem_readdata(mem_readdata[0]),
      .dbg_state_o(dbg_state[0])
   );

   dmem_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .i_address(i_address[1]), .i_read(i_read[1]), .i_readdata(i_readdata[1]),
      .i_waitrequest(i_waitrequest[1]),
      .d_address(d_address[1]), .d_read(d_read[1]), .d_write(d_write[1]),
      .d_writedata(d_writedata[1]), .d_readdata(d_readdata[1]), .d_waitrequest(d_waitrequest[1]),
      .mem_address(mem_address[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
      .mem_writedata(mem_writedata[1]), .mem_readdata(mem_readdata[1]),
      .dbg_state_o(dbg_state[1])
   );

   // ---------------- RAM models ----------------
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a == 32'h480) ? 32'h1234_5678 : {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   function automatic logic [31:0] ram_word(input int k, input logic [31:0] a);
      return wr_flag[k][a[11:2]] ? ram[k][a[11:2]] : init_word(a);
   endfunction

   assign mem_readdata[0] = wr_flag[0][mem_address[0][11:2]] ? ram[0][mem_address[0][11:2]]
                                                              : init_word(mem_address[0]);
   assign mem_readdata[1] = wr_flag[1][mem_address[1][11:2]] ? ram[1][mem_address[1][11:2]]
                                                              : init_word(mem_address[1]);

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_write[k]) begin
            ram[k][mem_address[k][11:2]]     <= mem_writedata[k];
            wr_flag[k][mem_address[k][11:2]] <= 1'b1;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_access(input int k, input bit wr, input logic [31:0] a,
                                                input logic [31:0] wd);
      if (wr) model_mem[k][a[11:2]] = wd;
      return model_mem[k][a[11:2]];
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         i_address[k] = '0; i_read[k] = 1'b0;
         d_address[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0; d_writedata[k] = '0;
      end
   endtask

   // Starts at posedge+1 (cycle 0); returns the cycle index in which each port completed.
   task automatic xfer(input int k, input bit use_i, input bit d_rd, input bit d_wr,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       output int i_done, output int d_done,
                       output logic [31:0] i_dat, output logic [31:0] d_dat);
      bit use_d;
      use_d  = d_rd | d_wr;
      i_done = -1; d_done = -1; i_dat = '0; d_dat = '0;
      i_address[k] = ia; i_read[k] = use_i;
      d_address[k] = da; d_read[k] = d_rd; d_write[k] = d_wr; d_writedata[k] = wd;
      for (int c = 0; c < 64; c++) begin
         if (!((use_i && i_done < 0) || (use_d && d_done < 0))) break;
         @(negedge clk);
         check("wait_excl", 32'(i_waitrequest[k] | d_waitrequest[k]), 32'd1);
         if (i_waitrequest[k] && d_waitrequest[k])
            check("strobe_quiet", 32'({mem_read[k], mem_write[k]}), 32'd0);
         if (use_i && i_done < 0 && !i_waitrequest[k]) begin
            i_done = c; i_dat = i_readdata[k];
            check("i_mem_addr", mem_address[k], ia);
         end
         if (use_d && d_done < 0 && !d_waitrequest[k]) begin
            d_done = c; d_dat = d_readdata[k];
            check("d_mem_addr", mem_address[k], da);
         end
         @(posedge clk); #1;
         if (i_done >= 0) i_read[k] = 1'b0;
         if (d_done >= 0) begin d_read[k] = 1'b0; d_write[k] = 1'b0; end
      end
      i_read[k] = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0;
   endtask

   task automatic run_case(input int k, input bit use_i, input bit d_rd, input bit d_wr,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
      int          w, i_exp, d_exp, i_done, d_done;
      bit          use_d;
      arb_port_t   first;
      logic [31:0] i_val, d_val, i_dat, d_dat;
      w     = (k == 0) ? 0 : 3;
      use_d = d_rd | d_wr;
      i_val = '0; d_val = '0;
      first = use_i ? PORT_I : PORT_D;
      if (use_i && use_d) first = (last_served[k] == PORT_I) ? PORT_D : PORT_I;
      i_exp = 2 + w;
      d_exp = 2 + w;
      if (use_i && use_d) begin
         if (first == PORT_I) d_exp = 5 + 2 * w;
         else                 i_exp = 5 + 2 * w;
      end
      if (first == PORT_I) begin
         if (use_i) i_val = model_access(k, 1'b0, ia, '0);
         if (use_d) d_val = model_access(k, d_wr, da, wd);
      end else begin
         if (use_d) d_val = model_access(k, d_wr, da, wd);
         if (use_i) i_val = model_access(k, 1'b0, ia, '0);
      end
      if (use_i) exp_q.push_back(i_val);
      if (use_d && !d_wr) exp_q.push_back(d_val);

      xfer(k, use_i, d_rd, d_wr, ia, da, wd, i_done, d_done, i_dat, d_dat);

      if (use_i) begin
         check("i_cycle", 32'(i_done), 32'(i_exp));
         check("i_rdata", i_dat, exp_q.pop_front());
      end
      if (use_d) begin
         check("d_cycle", 32'(d_done), 32'(d_exp));
         if (!d_wr) check("d_rdata", d_dat, exp_q.pop_front());
         else       check("ram_write", ram_word(k, da), d_val);
      end
      if (use_i && use_d) last_served[k] = (first == PORT_I) ? PORT_D : PORT_I;
      else                last_served[k] = first;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 1024; j++)
            model_mem[k][j] = init_word(32'(j) << 2);
      last_served[0] = PORT_D;
      last_served[1] = PORT_D;
      clear_inputs();
      rst_n = 1'b0;

      // Reset with random inputs
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            i_address[k] = $urandom; i_read[k] = 1'($urandom_range(0, 1));
            d_address[k] = $urandom; d_read[k] = 1'($urandom_range(0, 1));
            d_write[k] = 1'($urandom_range(0, 1)); d_writedata[k] = $urandom;
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check("rst_i_wait", 32'(i_waitrequest[k]), 32'd1);
            check("rst_d_wait", 32'(d_waitrequest[k]), 32'd1);
            check("rst_strobes", 32'({mem_read[k], mem_write[k]}), 32'd0);
            check("rst_addr", mem_address[k], 32'd0);
            check("rst_rdata", i_readdata[k] | d_readdata[k], 32'd0);
            check("rst_state", 32'(dbg_state[k]), 32'(ARB_IDLE));
         end
      end
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b1;

      // Zero wait states, single D read
      run_case(0, 1'b0, 1'b1, 1'b0, '0, 32'h480, '0);

      // Three wait states, write then read back
      run_case(1, 1'b0, 1'b0, 1'b1, '0, 32'h484, 32'hDEAD_BEEF);
      run_case(1, 1'b0, 1'b1, 1'b0, '0, 32'h484, '0);

      // Contention: both ports held, grants alternate
      for (int r = 0; r < 4; r++)
         run_case(0, 1'b1, 1'b1, 1'b0, 32'h480, 32'h484, '0);

      // Read and write together: write is performed
      run_case(0, 1'b0, 1'b1, 1'b1, '0, 32'h48C, 32'h0000_0001);

      // Abort: granted D drops during BUSY; last grant must stay with I
      run_case(1, 1'b1, 1'b0, 1'b0, 32'h490, '0, '0);
      d_address[1] = 32'h494; d_read[1] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      d_read[1] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("abort_wait", 32'({i_waitrequest[1], d_waitrequest[1]}), 32'd3);
         check("abort_strobe", 32'({mem_read[1], mem_write[1]}), 32'd0);
      end
      check("abort_state", 32'(dbg_state[1]), 32'(ARB_IDLE));
      @(posedge clk); #1;
      run_case(1, 1'b1, 1'b1, 1'b0, 32'h498, 32'h49C, '0);

      // Reset pulsed during BUSY of a write
      d_address[1] = 32'h488; d_writedata[1] = 32'hCAFE_F00D; d_write[1] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      check("pre_rst_state", 32'(dbg_state[1]), 32'(ARB_BUSY));
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_state", 32'(dbg_state[1]), 32'(ARB_IDLE));
      check("mid_rst_wait", 32'(d_waitrequest[1]), 32'd1);
      check("mid_rst_write", 32'(mem_write[1]), 32'd0);
      @(posedge clk); #1;
      d_write[1] = 1'b0;
      rst_n = 1'b1;
      last_served[0] = PORT_D;
      last_served[1] = PORT_D;
      check("ram_kept", ram_word(1, 32'h488), model_access(1, 1'b0, 32'h488, '0));
      run_case(1, 1'b0, 1'b0, 1'b1, '0, 32'h488, 32'hCAFE_F00D);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int          k, mode;
         logic [31:0] ia, da, wd;
         k    = $urandom_range(0, 1);
         mode = $urandom_range(0, 4);
         ia   = 32'h400 + (32'($urandom_range(0, 63)) << 2);
         da   = 32'h400 + (32'($urandom_range(0, 63)) << 2);
         wd   = $urandom;
         case (mode)
            0:       run_case(k, 1'b1, 1'b0, 1'b0, ia, da, wd);
            1:       run_case(k, 1'b0, 1'b1, 1'b0, ia, da, wd);
            2:       run_case(k, 1'b0, 1'b0, 1'b1, ia, da, wd);
            3:       run_case(k, 1'b1, 1'b1, 1'b0, ia, da, wd);
            default: run_case(k, 1'b1, 1'b0, 1'b1, ia, da, wd);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
